rtc_12h_bcd: RTL and testbench
==============================

// Module: rtc_12h_bcd
// PURPOSE
//  Free-running 12-hour real-time clock: seconds, minutes and hours in packed BCD, plus an AM/PM flag.
//  Sole source of the hours[7:0]/pm pair consumed by the peak/off-peak classifier and the TLC sequencer.
//  A 1-cycle set handshake lets the operator panel load the time of day.
//  Emits per-second/minute/hour strobes for downstream schedulers.
// PARAMETERS
//  TICKS_PER_SEC  50_000_000  clk cycles per second (benches use 10)
// PORTS
//  clk         in   1  system clock, all logic rising-edge
//  rst         in   1  synchronous, active-high reset
//  run         in   1  1 = time advances; 0 = prescaler and time frozen
//  set_valid   in   1  load request, sampled every clk
//  set_hours   in   8  BCD hours, legal 8'h01..8'h12
//  set_minutes in   8  BCD minutes, legal 8'h00..8'h59
//  set_pm      in   1  PM flag to load
//  set_ack     out  1  1-cycle pulse: load accepted
//  set_err     out  1  1-cycle pulse: load rejected, time unchanged
//  hours       out  8  BCD [7:4] tens, [3:0] units, 8'h01..8'h12
//  minutes     out  8  BCD 8'h00..8'h59
//  seconds     out  8  BCD 8'h00..8'h59
//  pm          out  1  0 = AM, 1 = PM
//  sec_pulse   out  1  1-cycle strobe on every seconds increment
//  min_pulse   out  1  1-cycle strobe when minutes increments
//  hour_pulse  out  1  1-cycle strobe when hours increments
// BEHAVIOUR
//  - Reset (rst=1 at clk edge), which also aborts any load:
//    hours=8'h12, minutes=8'h00, seconds=8'h00, pm=0 (midnight)
//    prescaler=0; all pulses and set_ack/set_err = 0
//  - Prescaler: counts 0..TICKS_PER_SEC-1 while run=1.
//    At terminal count it wraps to 0 and seconds advances in the same edge.
//  - Outputs are registered; sec_pulse is asserted in the cycle the new seconds value is visible.
//  - Seconds: 59 -> 00, carry to minutes.
//  - Minutes: 59 -> 00, carry to hours.
//    min_pulse and hour_pulse coincide with their sec_pulse.
//  - Hours sequence: 12 -> 01 -> ... -> 11 -> 12 (no 00, no 13).
//  - pm toggles only on the 11 -> 12 transition:
//    11:59:59 AM -> 12:00:00 PM; 11:59:59 PM -> 12:00:00 AM.
//    12:59:59 -> 01:00:00 keeps pm.
//  - BCD digits never hold A..F; each units digit carries to tens at 9.
//  - Load, at the clk edge where set_valid=1:
//    - If the fields are legal: next cycle hours/minutes/pm = inputs, seconds=00, prescaler=0.
//      set_ack=1 for that cycle; no pulses are generated by the load.
//    - If illegal (non-BCD nibble, hours 00 or >12, minutes >59): time unchanged, set_err=1 for one cycle.
//    - Load has priority over a coincident tick; that tick is dropped.
//    - Load works regardless of run.
//    - set_valid held high reloads every cycle, one ack per cycle.
//  - run=0: all state frozen, no pulses; resumes from the frozen prescaler value.
// STRUCTURE
//  - rtc_pkg:
//    - BCD digit typedef; reset constants (RST_HOURS=8'h12, RST_MIN=8'h00)
//    - limits (MIN_MAX=8'h59, HR_MAX=8'h12, HR_MIN=8'h01)
//    - function bcd2_legal(val, max)
//  - Sub-module bcd2_counter:
//    - two-digit BCD counter with ports clk, rst, en, load, load_val, wrap_max, wrap_to
//    - outputs q, carry (1-cycle)
//    - instantiated three times: seconds 59->00, minutes 59->00, hours 12->01
//  - Top holds the prescaler, pm toggle, set validation, and ack/err logic.
// TESTING (TICKS_PER_SEC=10)
//  1. rst 3 cycles, run=1: outputs 12:00:00 AM; first sec_pulse exactly 10 clks after rst drops.
//  2. Load 11:59 AM, wait 60 s: 12:00:00 with pm=1, min_pulse and hour_pulse coincide with sec_pulse.
//  3. Load 11:59 PM, wait 60 s: 12:00:00 AM.
//     Load 12:59, wait 60 s: 01:00:00 with pm unchanged.
//  4. Set 8'h13, 8'h00, 8'h1A and minutes 8'h60: set_err pulse each time, time unchanged, no set_ack.
//  5. set_valid on the same edge as the prescaler terminal count:
//     loaded value with seconds=00, no sec_pulse, next sec_pulse 10 clks later.
//  6. run=0 for 25 clks mid-second: no change and no pulses.
//     Assert rst mid-count: 12:00:00 AM next cycle.

Source files
------------

// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_pkg
//  Description : Shared types, constants and the BCD field validator for the
//                12-hour BCD real-time clock.
//                Contents:
//                  bcd_digit_t  - one packed BCD digit
//                  RST_HOURS / RST_MIN - time-of-day after reset (midnight)
//                  MIN_MAX / HR_MAX / HR_MIN - field limits in packed BCD
//                  bcd2_legal() - two-digit BCD value is well formed and <= max
//  Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [7:0] RST_HOURS = 8'h12;
    localparam logic [7:0] RST_MIN   = 8'h00;

    localparam logic [7:0] MIN_MAX   = 8'h59;
    localparam logic [7:0] HR_MAX    = 8'h12;
    localparam logic [7:0] HR_MIN    = 8'h01;

    // With both nibbles restricted to 0..9 a packed BCD value orders the same
    // way as its binary encoding, so a plain magnitude compare is valid.
    function automatic logic bcd2_legal(input logic [7:0] val, input logic [7:0] max);
        return (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val <= max);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd2_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd2_counter
//  Description : Two-digit packed BCD counter with synchronous load and a
//                programmable wrap (wrap_max -> wrap_to).
//                Ports:
//                  clk, rst          - clock, synchronous active-high reset
//                  en                - advance by one this cycle
//                  load, load_val    - overwrite the count (wins over en)
//                  wrap_max, wrap_to - value that wraps, and its successor
//                  q                 - current count
//                  carry             - strobe: this cycle's advance wraps
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd2_counter
    import rtc_pkg::*;
#(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic [7:0] wrap_max,
    input  logic [7:0] wrap_to,
    output logic [7:0] q,
    output logic       carry
);

    logic [7:0] q_q;
    logic [7:0] q_d;
    bcd_digit_t w_units;
    bcd_digit_t w_tens;

    always_comb begin
        w_units = q_q[3:0];
        w_tens  = q_q[7:4];
        q_d     = q_q;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            if (q_q == wrap_max) begin
                q_d = wrap_to;
            end else if (w_units == 4'd9) begin
                q_d = {w_tens + 4'd1, 4'd0};
            end else begin
                q_d = {w_tens, w_units + 4'd1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

    // Combinational so the next stage advances on the same edge as the wrap.
    assign carry = en && !load && (q_q == wrap_max);

endmodule
`default_nettype wire

// File: rtl/rtc_12h_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_12h_bcd
//  Description : Free-running 12-hour real-time clock in packed BCD with an
//                AM/PM flag, a validated one-cycle set handshake and
//                per-second/minute/hour strobes.
//                Ports:
//                  clk, rst                      - clock, sync active-high reset
//                  run                           - 1 = time advances
//                  set_valid, set_hours,
//                  set_minutes, set_pm           - load request and fields
//                  set_ack / set_err             - load accepted / rejected
//                  hours, minutes, seconds, pm   - time of day
//                  sec_pulse, min_pulse,
//                  hour_pulse                    - increment strobes
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_12h_bcd
    import rtc_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       set_valid,
    input  logic [7:0] set_hours,
    input  logic [7:0] set_minutes,
    input  logic       set_pm,
    output logic       set_ack,
    output logic       set_err,
    output logic [7:0] hours,
    output logic [7:0] minutes,
    output logic [7:0] seconds,
    output logic       pm,
    output logic       sec_pulse,
    output logic       min_pulse,
    output logic       hour_pulse
);

    localparam int                   C_PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [C_PRESC_W-1:0] C_TERM    = C_PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [C_PRESC_W-1:0] C_ONE     = C_PRESC_W'(1);

    logic [C_PRESC_W-1:0] presc_q, presc_d;
    logic                 pm_q, pm_d;
    logic                 sec_pulse_q, sec_pulse_d;
    logic                 min_pulse_q, min_pulse_d;
    logic                 hour_pulse_q, hour_pulse_d;
    logic                 set_ack_q, set_ack_d;
    logic                 set_err_q, set_err_d;

    logic                 w_tick;
    logic                 w_fields_legal;
    logic                 w_load_ok;
    logic                 w_load_bad;
    logic                 w_sec_en;
    logic                 w_min_en;
    logic                 w_hr_en;
    logic                 w_hr_wrap;
    logic [7:0]           w_sec;
    logic [7:0]           w_min;
    logic [7:0]           w_hr;

    always_comb begin
        w_tick         = run && (presc_q == C_TERM);
        w_fields_legal = bcd2_legal(set_hours, HR_MAX) && (set_hours >= HR_MIN)
                         && bcd2_legal(set_minutes, MIN_MAX);
        w_load_ok      = set_valid && w_fields_legal;
        w_load_bad     = set_valid && !w_fields_legal;
        // Any load request swallows a coincident tick so the time never
        // moves on the edge that services set_valid.
        w_sec_en       = w_tick && !set_valid;
    end

    bcd2_counter #(.RST_VAL(RST_MIN)) u_sec (
        .clk      (clk),
        .rst      (rst),
        .en       (w_sec_en),
        .load     (w_load_ok),
        .load_val (8'h00),
        .wrap_max (MIN_MAX),
        .wrap_to  (8'h00),
        .q        (w_sec),
        .carry    (w_min_en)
    );

    bcd2_counter #(.RST_VAL(RST_MIN)) u_min (
        .clk      (clk),
        .rst      (rst),
        .en       (w_min_en),
        .load     (w_load_ok),
        .load_val (set_minutes),
        .wrap_max (MIN_MAX),
        .wrap_to  (8'h00),
        .q        (w_min),
        .carry    (w_hr_en)
    );

    bcd2_counter #(.RST_VAL(RST_HOURS)) u_hr (
        .clk      (clk),
        .rst      (rst),
        .en       (w_hr_en),
        .load     (w_load_ok),
        .load_val (set_hours),
        .wrap_max (HR_MAX),
        .wrap_to  (HR_MIN),
        .q        (w_hr),
        .carry    (w_hr_wrap)
    );

    always_comb begin
        presc_d      = presc_q;
        pm_d         = pm_q;
        sec_pulse_d  = w_sec_en;
        min_pulse_d  = w_min_en;
        hour_pulse_d = w_hr_en;
        set_ack_d    = w_load_ok;
        set_err_d    = w_load_bad;

        if (w_load_ok) begin
            presc_d = '0;
        end else if (run) begin
            presc_d = w_tick ? '0 : presc_q + C_ONE;
        end

        // Meridiem flips entering 12 o'clock; the 12 -> 01 wrap keeps it.
        if (w_load_ok) begin
            pm_d = set_pm;
        end else if (w_hr_en && !w_hr_wrap && (w_hr == 8'h11)) begin
            pm_d = ~pm_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            pm_q         <= 1'b0;
            sec_pulse_q  <= 1'b0;
            min_pulse_q  <= 1'b0;
            hour_pulse_q <= 1'b0;
            set_ack_q    <= 1'b0;
            set_err_q    <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            pm_q         <= pm_d;
            sec_pulse_q  <= sec_pulse_d;
            min_pulse_q  <= min_pulse_d;
            hour_pulse_q <= hour_pulse_d;
            set_ack_q    <= set_ack_d;
            set_err_q    <= set_err_d;
        end
    end

    assign hours      = w_hr;
    assign minutes    = w_min;
    assign seconds    = w_sec;
    assign pm         = pm_q;
    assign sec_pulse  = sec_pulse_q;
    assign min_pulse  = min_pulse_q;
    assign hour_pulse = hour_pulse_q;
    assign set_ack    = set_ack_q;
    assign set_err    = set_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_12h_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtc_12h_bcd
//  Description : Self-checking bench for rtc_12h_bcd (TICKS_PER_SEC = 10).
//                Reference model keeps time as seconds-since-midnight and
//                derives the 12-hour BCD view arithmetically.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_12h_bcd;

    localparam int TPS = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       set_valid = 1'b0;
    logic [7:0] set_hours = 8'h12;
    logic [7:0] set_minutes = 8'h00;
    logic       set_pm = 1'b0;
    logic       set_ack, set_err, pm, sec_pulse, min_pulse, hour_pulse;
    logic [7:0] hours, minutes, seconds;

    always #5 clk = ~clk;

    rtc_12h_bcd #(.TICKS_PER_SEC(TPS)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .set_valid   (set_valid),
        .set_hours   (set_hours),
        .set_minutes (set_minutes),
        .set_pm      (set_pm),
        .set_ack     (set_ack),
        .set_err     (set_err),
        .hours       (hours),
        .minutes     (minutes),
        .seconds     (seconds),
        .pm          (pm),
        .sec_pulse   (sec_pulse),
        .min_pulse   (min_pulse),
        .hour_pulse  (hour_pulse)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int   m_t = 0;
    int   m_presc = 0;
    logic m_ack = 0, m_err = 0, m_sp = 0, m_mp = 0, m_hp = 0;

    typedef struct {
        logic [7:0] h;
        logic [7:0] m;
        logic       p;
        logic       legal;
    } set_vec_t;

    function automatic int bcd_val(input logic [7:0] v);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return -1;
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        return 8'((n / 10) * 16 + (n % 10));
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int   hv, mv;
        logic tick;
        m_ack = 0; m_err = 0; m_sp = 0; m_mp = 0; m_hp = 0;
        if (rst) begin
            m_t = 0;
            m_presc = 0;
        end else begin
            tick = run && (m_presc == TPS - 1);
            if (set_valid) begin
                hv = bcd_val(set_hours);
                mv = bcd_val(set_minutes);
                if (hv >= 1 && hv <= 12 && mv >= 0 && mv <= 59) begin
                    m_t = ((hv % 12) + (set_pm ? 12 : 0)) * 3600 + mv * 60;
                    m_presc = 0;
                    m_ack = 1;
                end else begin
                    m_err = 1;
                    if (run) m_presc = tick ? 0 : m_presc + 1;
                end
            end else if (run) begin
                if (tick) begin
                    m_presc = 0;
                    m_t  = (m_t + 1) % 86400;
                    m_sp = 1;
                    m_mp = (m_t % 60 == 0);
                    m_hp = (m_t % 3600 == 0);
                end else begin
                    m_presc++;
                end
            end
        end
    endtask

    task automatic check_model();
        int hh;
        hh = (m_t / 3600) % 12;
        if (hh == 0) hh = 12;
        check("model_hours",   hours,      to_bcd(hh));
        check("model_minutes", minutes,    to_bcd((m_t / 60) % 60));
        check("model_seconds", seconds,    to_bcd(m_t % 60));
        check("model_pm",      pm,         8'(m_t >= 43200));
        check("model_sec_pulse",  sec_pulse,  m_sp);
        check("model_min_pulse",  min_pulse,  m_mp);
        check("model_hour_pulse", hour_pulse, m_hp);
        check("model_set_ack", set_ack, m_ack);
        check("model_set_err", set_err, m_err);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic p);
        set_hours = h; set_minutes = m; set_pm = p; set_valid = 1'b1;
        step();
        set_valid = 1'b0;
        check("load_ack", set_ack, 8'd1);
    endtask

    // Cycles until the next sec_pulse, bounded; returns 255 on timeout.
    task automatic cycles_to_pulse(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!sec_pulse && n < 40);
        if (!sec_pulse) n = 255;
    endtask

    initial begin
        set_vec_t   vecs[10];
        logic [7:0] snap_h, snap_m, snap_s;
        logic       snap_p;
        int         n;

        vecs[0] = '{8'h13, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h30, 1'b0, 1'b0};
        vecs[2] = '{8'h1A, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h05, 8'h60, 1'b0, 1'b0};
        vecs[4] = '{8'h05, 8'h5F, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'h01, 8'h00, 1'b0, 1'b1};
        vecs[7] = '{8'h12, 8'h59, 1'b1, 1'b1};
        vecs[8] = '{8'h09, 8'h09, 1'b0, 1'b1};
        vecs[9] = '{8'h10, 8'h45, 1'b1, 1'b1};

        // 1. reset state and first-second latency
        rst = 1'b1; run = 1'b1;
        repeat (3) step();
        check("rst_hours",   hours,   8'h12);
        check("rst_minutes", minutes, 8'h00);
        check("rst_seconds", seconds, 8'h00);
        check("rst_pm",      pm,      8'd0);
        rst = 1'b0;
        cycles_to_pulse(n);
        check("first_sec_latency", 8'(n), 8'd10);

        // 2. 11:59 AM -> 12:00:00 PM
        do_load(8'h11, 8'h59, 1'b0);
        repeat (60 * TPS) step();
        check("am2pm_hours", hours, 8'h12);
        check("am2pm_min",   minutes, 8'h00);
        check("am2pm_sec",   seconds, 8'h00);
        check("am2pm_pm",    pm, 8'd1);
        check("am2pm_pulses", {5'd0, sec_pulse, min_pulse, hour_pulse}, 8'h07);

        // 3. 11:59 PM -> 12:00:00 AM; 12:59 -> 01:00:00 keeps pm
        do_load(8'h11, 8'h59, 1'b1);
        repeat (60 * TPS) step();
        check("pm2am_hours", hours, 8'h12);
        check("pm2am_pm",    pm, 8'd0);
        do_load(8'h12, 8'h59, 1'b1);
        repeat (60 * TPS) step();
        check("12to1_hours", hours, 8'h01);
        check("12to1_min",   minutes, 8'h00);
        check("12to1_pm",    pm, 8'd1);
        check("12to1_hour_pulse", hour_pulse, 8'd1);

        // 4. table of legal / illegal loads, time frozen
        run = 1'b0;
        foreach (vecs[i]) begin
            snap_h = hours; snap_m = minutes; snap_p = pm;
            set_hours = vecs[i].h; set_minutes = vecs[i].m; set_pm = vecs[i].p;
            set_valid = 1'b1;
            step();
            set_valid = 1'b0;
            check("tbl_ack", set_ack, vecs[i].legal);
            check("tbl_err", set_err, !vecs[i].legal);
            check("tbl_hours",   hours,   vecs[i].legal ? vecs[i].h : snap_h);
            check("tbl_minutes", minutes, vecs[i].legal ? vecs[i].m : snap_m);
            check("tbl_pm",      pm,      vecs[i].legal ? vecs[i].p : snap_p);
            step();
            check("tbl_ack_gone", set_ack, 8'd0);
        end

        // held set_valid: one ack per cycle
        set_hours = 8'h07; set_minutes = 8'h07; set_pm = 1'b0; set_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("held_ack", set_ack, 8'd1);
        end
        set_valid = 1'b0;

        // 5. load on the terminal-count edge drops the tick
        run = 1'b1;
        do_load(8'h03, 8'h15, 1'b1);
        repeat (TPS - 1) step();
        do_load(8'h04, 8'h20, 1'b0);
        check("tc_load_sec_pulse", sec_pulse, 8'd0);
        check("tc_load_seconds",   seconds,   8'h00);
        check("tc_load_hours",     hours,     8'h04);
        cycles_to_pulse(n);
        check("tc_load_next_pulse", 8'(n), 8'd10);

        // 6. freeze mid-second, then reset mid-count
        repeat (3) step();
        snap_h = hours; snap_m = minutes; snap_s = seconds;
        run = 1'b0;
        repeat (25) begin
            step();
            check("frz_sec_pulse", sec_pulse, 8'd0);
            check("frz_seconds",   seconds,   snap_s);
        end
        run = 1'b1;
        cycles_to_pulse(n);
        check("frz_resume_latency", 8'(n), 8'd7);
        repeat (4) step();
        rst = 1'b1;
        step();
        check("mid_rst_hours",   hours,   8'h12);
        check("mid_rst_minutes", minutes, 8'h00);
        check("mid_rst_seconds", seconds, 8'h00);
        check("mid_rst_pm",      pm,      8'd0);
        rst = 1'b0;

        // randomized run against the model
        for (int c = 0; c < 6000; c++) begin
            run       = ($urandom_range(0, 9) != 0);
            rst       = ($urandom_range(0, 2999) == 0);
            set_valid = ($urandom_range(0, 299) == 0);
            set_pm    = 1'($urandom_range(0, 1));
            set_hours = ($urandom_range(0, 3) != 0) ? to_bcd($urandom_range(1, 12))
                                                    : 8'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    set_minutes = 8'h59;
                2:       set_minutes = to_bcd($urandom_range(0, 59));
                default: set_minutes = 8'($urandom);
            endcase
            step();
        end
        rst = 1'b0; set_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
